// File: rtl/dmem_responder_pkg.sv
// Shared rvga types used by the data-memory responder.
package rvga_types;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } rvga_dmem_state;

endpackage

// File: rtl/dmem_responder_sram.sv
// Single-port RAM with registered, write-first read; the read register moves only on en_i.
module sram_1rw #(
    parameter int width_p = 32,
    parameter int depth_p = 1024
) (
    input  logic                       clk_i,
    input  logic                       en_i,
    input  logic                       we_i,
    input  logic [$clog2(depth_p)-1:0] addr_i,
    input  logic [width_p-1:0]         data_i,
    output logic [width_p-1:0]         data_o
);

    logic [width_p-1:0] r_mem [depth_p];
    logic [width_p-1:0] r_data;

    always_ff @(posedge clk_i) begin
        if (we_i) r_mem[addr_i] <= data_i;
        if (en_i) r_data <= we_i ? data_i : r_mem[addr_i];
    end

    assign data_o = r_data;

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the dmem interface: decodes the address, stalls the pipeline
// for latency_p cycles on a read and presents the word in the following cycle.
module dmem_responder
    import rvga_types::*;
#(
    parameter int          depth_p     = 1024,
    parameter int          latency_p   = 1,
    parameter logic [31:0] base_addr_p = 32'h0000_0000
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     dmem_r_v_i,
    input  logic     dmem_w_v_i,
    input  rvga_word dmem_addr_i,
    input  rvga_word dmem_data_i,
    output rvga_word dmem_data_o,
    output logic     stall_v_o,
    output logic     oob_o
);

    localparam int              aw_lp   = $clog2(depth_p);
    localparam int              cw_lp   = (latency_p > 1) ? $clog2(latency_p) : 1;
    localparam logic [32:0]     span_lp = 33'(depth_p) * 33'd4;
    localparam logic [cw_lp-1:0] cnt_init_lp = cw_lp'(latency_p - 1);

    rvga_dmem_state   r_state;
    logic [cw_lp-1:0] r_cnt;
    logic             r_oob;
    logic             r_rd_zero;

    rvga_word          w_offset;
    logic              w_in_range;
    logic [aw_lp-1:0]  w_idx;
    logic              w_last;
    logic              w_wr;
    rvga_word          w_ram_q;

    assign w_offset   = dmem_addr_i - base_addr_p;
    assign w_in_range = {1'b0, w_offset} < span_lp;
    assign w_idx      = w_offset[aw_lp+1:2];

    // The RAM is read in the final stall cycle (address is held stable), so its
    // read register updates exactly on the edge entering DONE.
    assign w_last = ((r_state == IDLE) && dmem_r_v_i && (latency_p == 1)) ||
                    ((r_state == WAIT) && (r_cnt == cw_lp'(1)));
    assign w_wr   = (r_state == IDLE) && dmem_w_v_i && !dmem_r_v_i && w_in_range;

    sram_1rw #(
        .width_p(32),
        .depth_p(depth_p)
    ) u_sram (
        .clk_i (clk_i),
        .en_i  (w_last && w_in_range),
        .we_i  (w_wr),
        .addr_i(w_idx),
        .data_i(dmem_data_i),
        .data_o(w_ram_q)
    );

    always_comb begin
        stall_v_o = 1'b0;
        case (r_state)
            IDLE:    stall_v_o = dmem_r_v_i;
            WAIT:    stall_v_o = 1'b1;
            default: stall_v_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_oob     <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            r_oob <= 1'b0;
            if (w_last) r_rd_zero <= !w_in_range;
            case (r_state)
                IDLE: begin
                    if (dmem_r_v_i) begin
                        r_cnt   <= cnt_init_lp;
                        r_state <= (latency_p == 1) ? DONE : WAIT;
                        r_oob   <= !w_in_range || dmem_w_v_i;
                    end else if (dmem_w_v_i) begin
                        r_oob   <= !w_in_range;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - cw_lp'(1);
                    if (r_cnt == cw_lp'(1)) r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Out-of-range reads and post-reset state present zero instead of the RAM register.
    assign dmem_data_o = r_rd_zero ? 32'h0000_0000 : w_ram_q;
    assign oob_o       = r_oob;

endmodule
